// File: rtl/spi_master.sv
// Mode-0, MSB-first SPI master with a valid/ready byte stream in and a pulsed byte stream out.
// Define SPI_MASTER_LOOPBACK_EN to sample the internal MOSI register instead of MISO.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, WAIT, TRAIL, GAP} state_t;

  state_t        state_q;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q;
  logic [6:0]    tx_sr_q;
  logic [7:0]    rx_sr_q, rx_byte_q;
  logic          last_q, sck_q, ssel_q, mosi_q, ready_q, rxv_q;
  logic          expire, rx_bit;

  assign expire = (div_q == DW'(CLK_DIV - 1));
  assign div_d  = expire ? '0 : div_q + 1'b1;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = MISO;
  assign rx_bit      = mosi_q;
`else
  assign rx_bit      = MISO;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_byte_q <= '0;
      last_q    <= 1'b0;
      sck_q     <= 1'b0;
      ssel_q    <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b0;
      rxv_q     <= 1'b0;
    end else begin
      rxv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (tx_valid && ready_q) begin
            tx_sr_q <= tx_byte[6:0];
            last_q  <= tx_last;
            mosi_q  <= tx_byte[7];
            ssel_q  <= 1'b0;
            ready_q <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= LEAD;
          end
        end
        LEAD: begin
          div_q <= div_d;
          if (expire) state_q <= SHIFT;
        end
        SHIFT: begin
          div_q <= div_d;
          if (expire) begin
            if (!sck_q) begin
              sck_q   <= 1'b1;
              rx_sr_q <= {rx_sr_q[6:0], rx_bit};
              bit_q   <= bit_q + 4'd1;
            end else begin
              sck_q <= 1'b0;
              if (bit_q != 4'd8) begin
                mosi_q  <= tx_sr_q[6];
                tx_sr_q <= {tx_sr_q[5:0], 1'b0};
              end else begin
                rx_byte_q <= rx_sr_q;
                rxv_q     <= 1'b1;
                state_q   <= last_q ? TRAIL : WAIT;
              end
            end
          end
        end
        WAIT: begin
          // ready is held low during the rx_valid cycle so the two never coincide
          ready_q <= 1'b1;
          if (tx_valid && ready_q) begin
            tx_sr_q <= tx_byte[6:0];
            last_q  <= tx_last;
            mosi_q  <= tx_byte[7];
            ready_q <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= SHIFT;
          end
        end
        TRAIL: begin
          div_q <= div_d;
          if (expire) begin
            ssel_q  <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          div_q <= div_d;
          if (expire) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready = ready_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rxv_q;
  assign busy     = (state_q != IDLE);
  assign SCK      = sck_q;
  assign SSEL     = ssel_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (CLK_DIV=4) with a mode-0 slave model on MISO.
module tb_spi_master;

  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       busy;
  logic       SCK, SSEL, MOSI, MISO;

  int checks = 0;
  int failures = 0;

  spi_master #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_last(tx_last), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy),
    .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  // Slave model: bit index advances on each SCK fall, restarts whenever SSEL is high.
  logic [7:0] slv_data = 8'h00;
  logic [2:0] sidx = 3'd0;
  always @(negedge SCK or posedge SSEL) begin
    if (SSEL) sidx <= 3'd0;
    else      sidx <= sidx + 3'd1;
  end
`ifdef SPI_MASTER_LOOPBACK_EN
  assign MISO = 1'b0;
`else
  assign MISO = slv_data[~sidx];
`endif

  // Pin monitor sampled on the falling clk edge.
  int         cyc = 0, rise_cnt = 0, ssel_low = 0, ssel_rise = 0;
  int         rxv_cnt = 0, rxv_cyc = 0, rxv_prev = 0, hs_cnt = 0, hs_cyc = 0, overlap = 0;
  logic       sck_prev = 1'b0, ssel_prev = 1'b1;
  logic [7:0] mosi_cap = 8'h00;
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    sck_prev  <= SCK;
    ssel_prev <= SSEL;
    if (SCK && !sck_prev) begin
      rise_cnt <= rise_cnt + 1;
      mosi_cap <= {mosi_cap[6:0], MOSI};
    end
    if (!SSEL) ssel_low <= ssel_low + 1;
    if (SSEL && !ssel_prev) ssel_rise <= ssel_rise + 1;
    if (rx_valid) begin
      rxv_cnt  <= rxv_cnt + 1;
      rxv_prev <= rxv_cyc;
      rxv_cyc  <= cyc;
    end
    if (tx_valid && tx_ready) begin
      hs_cnt <= hs_cnt + 1;
      hs_cyc <= cyc;
      if (rx_valid) overlap <= overlap + 1;
    end
  end

  function automatic logic [7:0] exp_rx(input logic [7:0] txb, input logic [7:0] slv);
`ifdef SPI_MASTER_LOOPBACK_EN
    return txb;
`else
    return slv;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Caller is positioned just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] b, input logic l);
    int n;
    tx_byte = b; tx_last = l; tx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready && n < LIMIT);
    if (n >= LIMIT) chk("send_timeout", 32'(n), 32'(LIMIT - 1));
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < LIMIT);
    @(negedge clk);
    if (n >= LIMIT) chk("idle_timeout", 32'(n), 32'(LIMIT - 1));
  endtask

  task automatic wait_rxv();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_valid && n < LIMIT);
    if (n >= LIMIT) chk("rxv_timeout", 32'(n), 32'(LIMIT - 1));
  endtask

  initial begin
    int r0, v0, l0, s0, h0, bad;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ssel", 32'(SSEL), 32'd1);
    chk("rst_sck", 32'(SCK), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_rx_byte", 32'(rx_byte), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Single byte 0xA5, slave returns 0x3C
    slv_data = 8'h3C;
    r0 = rise_cnt; v0 = rxv_cnt; l0 = ssel_low;
    send(8'hA5, 1'b1);
    wait_idle();
    chk("t1_mosi", 32'(mosi_cap), 32'hA5);
    chk("t1_rises", 32'(rise_cnt - r0), 32'd8);
    chk("t1_rxv_pulses", 32'(rxv_cnt - v0), 32'd1);
    chk("t1_rx_byte", 32'(rx_byte), 32'(exp_rx(8'hA5, 8'h3C)));
    chk("t1_ssel_low", 32'(ssel_low - l0), 32'd72);

    // Back-to-back 0x01, 0x02(last) with tx_valid held
    @(posedge clk); #1;
    slv_data = 8'h96;
    r0 = rise_cnt; v0 = rxv_cnt; s0 = ssel_rise;
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    wait_idle();
    chk("t2_rises", 32'(rise_cnt - r0), 32'd16);
    chk("t2_ssel_rises", 32'(ssel_rise - s0), 32'd1);
    chk("t2_rxv_pulses", 32'(rxv_cnt - v0), 32'd2);
    chk("t2_hs_after_rxv", 32'(hs_cyc - rxv_prev), 32'd1);
    chk("t2_overlap", 32'(overlap), 32'd0);
    chk("t2_mosi", 32'(mosi_cap), 32'h02);
    chk("t2_rx_byte", 32'(rx_byte), 32'(exp_rx(8'h02, 8'h96)));

    // 0x11 then a 20-cycle stall before the final byte
    @(posedge clk); #1;
    slv_data = 8'hF0;
    s0 = ssel_rise;
    send(8'h11, 1'b0);
    wait_rxv();
    chk("t3_rx_first", 32'(rx_byte), 32'(exp_rx(8'h11, 8'hF0)));
    r0 = rise_cnt; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (SCK !== 1'b0 || SSEL !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("t3_stall_pins", 32'(bad), 32'd0);
    chk("t3_stall_rises", 32'(rise_cnt - r0), 32'd0);
    chk("t3_stall_ssel", 32'(ssel_rise - s0), 32'd0);
    @(posedge clk); #1;
    send(8'h4B, 1'b1);
    wait_idle();
    chk("t3_rises", 32'(rise_cnt - r0), 32'd8);
    chk("t3_mosi", 32'(mosi_cap), 32'h4B);
    chk("t3_rx_byte", 32'(rx_byte), 32'(exp_rx(8'h4B, 8'hF0)));

    // 0x77 offered during SHIFT is held off until WAIT
    @(posedge clk); #1;
    slv_data = 8'h5E;
    send(8'h33, 1'b0);
    h0 = hs_cnt;
    repeat (10) begin @(posedge clk); #1; end
    tx_byte = 8'h77; tx_last = 1'b1; tx_valid = 1'b1;
    @(negedge clk);
    chk("t4_ready_in_shift", 32'(tx_ready), 32'd0);
    wait_rxv();
    chk("t4_no_early_hs", 32'(hs_cnt - h0), 32'd0);
    @(posedge clk); #1;
    send(8'h77, 1'b1);
    wait_idle();
    chk("t4_hs_count", 32'(hs_cnt - h0), 32'd1);
    chk("t4_mosi", 32'(mosi_cap), 32'h77);
    chk("t4_rx_byte", 32'(rx_byte), 32'(exp_rx(8'h77, 8'h5E)));

    // Asynchronous reset after 3 SCK rises, then a clean 0xC3 transfer
    @(posedge clk); #1;
    slv_data = 8'hFF;
    r0 = rise_cnt; v0 = rxv_cnt;
    send(8'hE7, 1'b1);
    bad = 0;
    while (rise_cnt - r0 < 3 && bad < LIMIT) begin
      @(negedge clk);
      bad++;
    end
    chk("t5_three_rises", 32'(rise_cnt - r0), 32'd3);
    chk("t5_sck_high_before", 32'(SCK), 32'd1);
    rst = 1'b1; #1;
    chk("t5_rst_ssel", 32'(SSEL), 32'd1);
    chk("t5_rst_sck", 32'(SCK), 32'd0);
    chk("t5_rst_mosi", 32'(MOSI), 32'd0);
    chk("t5_rst_rx_valid", 32'(rx_valid), 32'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_rxv", 32'(rxv_cnt - v0), 32'd0);
    @(posedge clk); #1;
    slv_data = 8'h81;
    r0 = rise_cnt;
    send(8'hC3, 1'b1);
    wait_idle();
    chk("t5_rises", 32'(rise_cnt - r0), 32'd8);
    chk("t5_mosi", 32'(mosi_cap), 32'hC3);
    chk("t5_rx_byte", 32'(rx_byte), 32'(exp_rx(8'hC3, 8'h81)));
    chk("t5_rxv_pulses", 32'(rxv_cnt - v0), 32'd1);

    // 0x5A against a slave returning 0x00 (loopback build returns the sent byte)
    @(posedge clk); #1;
    slv_data = 8'h00;
    send(8'h5A, 1'b1);
    wait_idle();
    chk("t6_mosi", 32'(mosi_cap), 32'h5A);
    chk("t6_rx_byte", 32'(rx_byte), 32'(exp_rx(8'h5A, 8'h00)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
